// File: rtl/result_bank_writer.sv
// Purpose: drops the first SKIP pixels of a frame, then writes the rest in raster order across NUM_BANKS banks.
// Latency: 1 cycle from an accepted pixel to its write strobe; done appears together with the last strobe.
// Backpressure: none; pixels arriving outside a frame are dropped and set the sticky overflow flag.
module result_bank_writer #(
    parameter int DATA_W     = 8,
    parameter int NUM_BANKS  = 8,
    parameter int BANK_DEPTH = 8192,
    parameter int SKIP       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          pix_valid,
    input  logic [DATA_W-1:0]             pix_in,
    output logic [NUM_BANKS-1:0]          wr_en,
    output logic [$clog2(BANK_DEPTH)-1:0] wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int ADDR_W = $clog2(BANK_DEPTH);
    localparam int TOTAL  = NUM_BANKS * BANK_DEPTH;
    localparam int K_W    = $clog2(TOTAL);
    localparam int SK_W   = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    localparam logic [K_W-1:0]  K_LAST  = K_W'(TOTAL - 1);
    localparam logic [SK_W-1:0] SK_LAST = SK_W'((SKIP > 0) ? SKIP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WRITE, S_DONE} state_t;

    // With nothing to discard the frame starts writing straight away.
    localparam state_t FIRST_STATE = (SKIP > 0) ? S_ARM : S_WRITE;

    state_t                state, state_nxt;
    logic [K_W-1:0]        k, k_nxt;
    logic [SK_W-1:0]       sk, sk_nxt;

    logic [NUM_BANKS-1:0]  wr_en_nxt;
    logic [ADDR_W-1:0]     wr_addr_nxt;
    logic [DATA_W-1:0]     wr_data_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic                  overflow_nxt;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= '0;
            sk    <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            sk    <= sk_nxt;
        end
    end

    // Next state: start is only honoured outside a frame; counters advance on valid pixels only.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        sk_nxt    = sk;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = FIRST_STATE;
                    k_nxt     = '0;
                    sk_nxt    = '0;
                end
            end
            S_ARM: begin
                if (pix_valid) begin
                    sk_nxt = sk + 1'b1;
                    if (sk == SK_LAST) state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (pix_valid) begin
                    // k wraps to 0 on the last pixel, but the move to DONE makes that harmless.
                    k_nxt = k + 1'b1;
                    if (k == K_LAST) state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output values for the next cycle; busy/done follow the next state so they line up with the final strobe.
    always_comb begin
        wr_en_nxt    = '0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        busy_nxt     = (state_nxt == S_ARM) || (state_nxt == S_WRITE);
        done_nxt     = (state_nxt == S_DONE);
        overflow_nxt = overflow;
        if (state == S_WRITE && pix_valid) begin
            // Upper counter bits pick the bank, lower bits are the in-bank address.
            wr_en_nxt   = NUM_BANKS'(1) << (k >> ADDR_W);
            wr_addr_nxt = k[ADDR_W-1:0];
            wr_data_nxt = pix_in;
        end
        if ((state == S_IDLE || state == S_DONE) && pix_valid && !start) begin
            overflow_nxt = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            overflow <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_result_bank_writer.sv
// Bench for result_bank_writer: default-size full frame, a small SKIP=0 instance driven by a vector
// table and directed sequences, and a small SKIP=3 instance driven randomly against a frame-level model.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_result_bank_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default configuration instance
    logic        b_rst, b_start, b_valid;
    logic [7:0]  b_d, b_en, b_data;
    logic [12:0] b_addr;
    logic        b_busy, b_done, b_ovf;

    result_bank_writer u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .pix_valid(b_valid), .pix_in(b_d),
        .wr_en(b_en), .wr_addr(b_addr), .wr_data(b_data),
        .busy(b_busy), .done(b_done), .overflow(b_ovf)
    );

    // Small instance, SKIP=0
    logic        s_rst, s_start, s_valid;
    logic [7:0]  s_d, s_data;
    logic [3:0]  s_en, s_addr;
    logic        s_busy, s_done, s_ovf;

    result_bank_writer #(.DATA_W(8), .NUM_BANKS(4), .BANK_DEPTH(16), .SKIP(0)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .pix_valid(s_valid), .pix_in(s_d),
        .wr_en(s_en), .wr_addr(s_addr), .wr_data(s_data),
        .busy(s_busy), .done(s_done), .overflow(s_ovf)
    );

    // Small instance, SKIP=3, random stimulus
    logic        r_rst, r_start, r_valid;
    logic [7:0]  r_d, r_data;
    logic [3:0]  r_en, r_addr;
    logic        r_busy, r_done, r_ovf;

    result_bank_writer #(.DATA_W(8), .NUM_BANKS(4), .BANK_DEPTH(16), .SKIP(3)) u_rand (
        .clk(clk), .rst(r_rst), .start(r_start), .pix_valid(r_valid), .pix_in(r_d),
        .wr_en(r_en), .wr_addr(r_addr), .wr_data(r_data),
        .busy(r_busy), .done(r_done), .overflow(r_ovf)
    );

    typedef struct {
        logic       rst, start, valid;
        logic [7:0] d;
        logic [3:0] en, addr;
        logic [7:0] data;
        logic       busy, done, ovf;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [7:0] d,
                                input logic [3:0] en, input logic [3:0] a, input logic [7:0] dt,
                                input logic bz, input logic dn, input logic ov);
        vec_t t;
        t.rst = r; t.start = s; t.valid = v; t.d = d;
        t.en = en; t.addr = a; t.data = dt; t.busy = bz; t.done = dn; t.ovf = ov;
        return t;
    endfunction

    function automatic logic [18:0] s_out();
        return {s_en, s_addr, s_data, s_busy, s_done, s_ovf};
    endfunction

    // Frame-level reference for u_rand: counts pixels since start, derives bank/address arithmetically.
    int         m_mode;     // 0 idle, 1 in frame, 2 frame complete
    int         m_n;        // valid pixels taken since start
    logic       m_ovf;
    logic [3:0] m_en, m_addr;
    logic [7:0] m_data;

    task automatic model_step(input logic rst, input logic start, input logic valid, input logic [7:0] d);
        int idx;
        if (rst) begin
            m_mode = 0; m_n = 0; m_ovf = 1'b0; m_en = '0; m_addr = '0; m_data = '0;
        end else begin
            m_en = '0;
            if (m_mode != 1) begin
                if (start) begin
                    m_mode = 1;
                    m_n    = 0;
                end else if (valid) begin
                    m_ovf = 1'b1;
                end
            end else if (valid) begin
                if (m_n >= 3) begin
                    idx    = m_n - 3;
                    m_en   = 4'(1 << (idx / 16));
                    m_addr = 4'(idx % 16);
                    m_data = d;
                    if (idx == 63) m_mode = 2;
                end
                m_n++;
            end
        end
    endtask

    initial begin
        logic [7:0]  one8;
        logic [3:0]  one4;
        logic [3:0]  last_addr;
        logic [7:0]  last_data;
        int          bad;
        logic        ok;

        one8 = 8'd1;
        one4 = 4'd1;
        b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_d = '0;
        s_rst = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_d = '0;
        r_rst = 1'b1; r_start = 1'b0; r_valid = 1'b0; r_d = '0;

        //              rst   start valid d      | en    addr  data   busy  done  ovf
        tbl[0]  = mk(1'b1, 1'b1, 1'b1, 8'hAA, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 8'hAB, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 8'h11, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 8'h21, 4'h1, 4'h0, 8'h21, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 8'h99, 4'h0, 4'h0, 8'h21, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 8'h98, 4'h0, 4'h0, 8'h21, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 8'h22, 4'h1, 4'h1, 8'h22, 1'b1, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, 8'h23, 4'h1, 4'h2, 8'h23, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 8'h24, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 8'h05, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 8'h06, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 1'b1, 1'b1, 8'h07, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1);

        tick();

        // Small instance: vector table
        for (int i = 0; i < 12; i++) begin
            s_rst = tbl[i].rst; s_start = tbl[i].start; s_valid = tbl[i].valid; s_d = tbl[i].d;
            tick();
            check($sformatf("vec%0d", i), 64'(s_out()),
                  64'({tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].busy, tbl[i].done, tbl[i].ovf}));
        end
        s_start = 1'b0;

        // Small instance: 37 writes, then reset mid-frame
        for (int j = 0; j < 37; j++) begin
            s_valid = 1'b1; s_d = 8'(j + 8'h40);
            tick();
            check($sformatf("mid_wr%0d", j), 64'({s_en, s_addr, s_data, s_done}),
                  64'({one4 << (j / 16), 4'(j % 16), 8'(j + 8'h40), 1'b0}));
        end
        s_rst = 1'b1; s_valid = 1'b1;
        tick();
        check("mid_rst", 64'(s_out()), 64'd0);
        s_rst = 1'b0; s_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("post_rst_idle", 64'(s_out()), 64'd0);
        end

        // Small instance: fresh frame, gapped stream 1,0,0,1,...
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("sm_start_busy", 64'({s_busy, s_done, s_en}), 64'({1'b1, 1'b0, 4'h0}));
        for (int j = 0; j < 64; j++) begin
            s_valid = 1'b1; s_d = 8'(j * 3 + 1);
            tick();
            check($sformatf("gap_wr%0d", j), 64'({s_en, s_addr, s_data, s_busy, s_done}),
                  64'({one4 << (j / 16), 4'(j % 16), 8'(j * 3 + 1), j != 63, j == 63}));
            last_addr = 4'(j % 16);
            last_data = 8'(j * 3 + 1);
            if (j < 63) begin
                for (int g = 0; g < 2; g++) begin
                    s_valid = 1'b0; s_d = 8'($urandom);
                    tick();
                    check("gap_idle", 64'({s_en, s_addr, s_data, s_done}),
                          64'({4'h0, last_addr, last_data, 1'b0}));
                end
            end
        end
        s_valid = 1'b1; s_d = 8'h5A;
        tick();
        check("done_ovf", 64'({s_en, s_busy, s_done, s_ovf}), 64'({4'h0, 1'b0, 1'b1, 1'b1}));
        s_valid = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("sm_restart", 64'({s_busy, s_done, s_ovf}), 64'({1'b1, 1'b0, 1'b1}));
        s_valid = 1'b1; s_d = 8'h77;
        tick();
        s_valid = 1'b0;
        check("sm_restart_wr", 64'({s_en, s_addr, s_data}), 64'({4'h1, 4'h0, 8'h77}));
        s_rst = 1'b1;

        // Random instance against the frame-level model
        for (int c = 0; c < 3000; c++) begin
            r_rst   = (c < 2) || ($urandom_range(0, 249) == 0);
            r_start = ($urandom_range(0, 15) == 0);
            r_valid = ($urandom_range(0, 3) != 0);
            r_d     = 8'($urandom);
            tick();
            model_step(r_rst, r_start, r_valid, r_d);
            check("rand", 64'({r_en, r_addr, r_data, r_busy, r_done, r_ovf}),
                  64'({m_en, m_addr, m_data, m_mode == 1, m_mode == 2, m_ovf}));
        end
        r_rst = 1'b1;

        // Default instance: reset with random inputs
        for (int j = 0; j < 2; j++) begin
            b_rst = 1'b1; b_start = 1'($urandom); b_valid = 1'($urandom); b_d = 8'($urandom);
            tick();
            check("big_rst", 64'({b_en, b_addr, b_data, b_busy, b_done, b_ovf}), 64'd0);
        end
        b_rst = 1'b0; b_start = 1'b1; b_valid = 1'b0;
        tick();
        b_start = 1'b0;
        check("big_start", 64'({b_busy, b_done, b_en}), 64'({1'b1, 1'b0, 8'h00}));

        // Default instance: full frame, start pulsed at k=100 must be ignored
        bad = 0;
        for (int i = 0; i < 65538; i++) begin
            b_valid = 1'b1; b_d = 8'(i); b_start = (i == 102);
            tick();
            if (i < 2)
                ok = (b_en == 8'h00) && !b_done && b_busy;
            else
                ok = (b_en == (one8 << ((i - 2) / 8192))) && (b_addr == 13'((i - 2) % 8192)) &&
                     (b_data == 8'(i)) && (b_done == (i == 65537)) && (b_busy == (i != 65537));
            if (!ok) bad++;
            if (i == 1)
                check("big_skip", 64'(b_en), 64'd0);
            if (i == 2)
                check("big_first", 64'({b_en, b_addr, b_data}), 64'({8'h01, 13'd0, 8'd2}));
            if (i == 8194)
                check("big_bank1", 64'({b_en, b_addr, b_data}), 64'({8'h02, 13'd0, 8'd2}));
            if (i == 65537)
                check("big_last", 64'({b_en, b_addr, b_done, b_busy}), 64'({8'h80, 13'd8191, 1'b1, 1'b0}));
        end
        b_start = 1'b0;
        check("big_stream", 64'(bad), 64'd0);
        b_valid = 1'b0;
        tick();
        check("big_done_hold", 64'({b_en, b_busy, b_done, b_ovf}), 64'({8'h00, 1'b0, 1'b1, 1'b0}));

        // Default instance: restart after done
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("big_restart", 64'({b_busy, b_done}), 64'({1'b1, 1'b0}));
        for (int j = 0; j < 3; j++) begin
            b_valid = 1'b1; b_d = 8'(7 + j);
            tick();
            if (j < 2)
                check("big_re_skip", 64'(b_en), 64'd0);
            else
                check("big_re_wr", 64'({b_en, b_addr, b_data}), 64'({8'h01, 13'd0, 8'd9}));
        end
        b_valid = 1'b0; b_rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
